// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and width helpers for the IFU set-associative cache.
//   - offset_width/index_width/tag_width: derive address-field widths from
//     the cache geometry parameters of the instantiating module.
//   - t_ifu_cache_state: miss-handling FSM states.
//   - t_tag_entry: {valid, tag} entry, sized for the default geometry.
package ifu_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_NUM_SETS   = 4;

    // Byte-offset bits inside one line.
    function automatic int offset_width(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    // Set-index bits.
    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag bits left after index and offset are removed.
    function automatic int tag_width(input int addr_width, input int line_width,
                                     input int num_sets);
        return addr_width - index_width(num_sets) - offset_width(line_width);
    endfunction

    localparam int DEF_OFFSET_WIDTH = offset_width(DEF_LINE_WIDTH);
    localparam int DEF_INDEX_WIDTH  = index_width(DEF_NUM_SETS);
    localparam int DEF_TAG_WIDTH    = tag_width(DEF_ADDR_WIDTH, DEF_LINE_WIDTH, DEF_NUM_SETS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESPOND   = 2'd3
    } t_ifu_cache_state;

    typedef struct packed {
        logic                     valid;
        logic [DEF_TAG_WIDTH-1:0] tag;
    } t_tag_entry;

endpackage

// File: rtl/ifu_plru_tree.sv
// ifu_plru_tree: combinational tree-PLRU helper for one set.
//   tree       in  NUM_WAYS-1 bits, node i has children 2i+1 / 2i+2,
//                  bit 0 = victim is in the left subtree
//   access_way in  way being hit or filled
//   victim     out way the current tree points at
//   next_tree  out tree after touching access_way (path points away from it)
module ifu_plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    output logic [NUM_WAYS-2:0]         next_tree
);

    localparam int WAY_WIDTH = $clog2(NUM_WAYS);

    // Walk from the root following the stored bits; each bit is one victim-index bit, MSB first.
    always_comb begin
        int   node_s;
        logic bit_s;
        victim = '0;
        node_s = 0;
        bit_s  = 1'b0;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            bit_s = 1'b0;
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node_s) begin
                    bit_s = tree[n];
                end else begin
                    bit_s = bit_s;
                end
            end
            victim = (victim << 1) | WAY_WIDTH'(bit_s);
            node_s = 2 * node_s + 1 + int'(bit_s);
        end
    end

    // Node on level l of the path to way w is (2^l - 1) + (w >> (WAY_WIDTH - l)).
    always_comb begin
        next_tree = tree;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == (1 << l) - 1 + int'(access_way >> (WAY_WIDTH - l))) begin
                    next_tree[n] = ~access_way[WAY_WIDTH-1-l];
                end else begin
                    next_tree[n] = next_tree[n];
                end
            end
        end
    end

endmodule

// File: rtl/ifu_sa_cache.sv
// ifu_sa_cache: N-way set-associative instruction cache with per-set
// tree-PLRU replacement and one blocking outstanding miss.
//   Clock/Rst_n               clock, asynchronous active-low reset
//   cpu_req*/cpu_rsp*         fetch request (valid/ready) and one-cycle response
//   mem_req*/mem_rsp*         line-fill request (valid/ready) and fill data
//   flushIn                   invalidate whole cache (deferred until IDLE)
//   hitStatusOut              last accepted request hit
module ifu_sa_cache
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 4
) (
    input  logic                                          Clock,
    input  logic                                          Rst_n,
    input  logic                                          cpu_reqValidIn,
    input  logic [ADDR_WIDTH-1:0]                         cpu_reqAddrIn,
    output logic                                          cpu_reqReadyOut,
    output logic                                          cpu_rspValidOut,
    output logic [ADDR_WIDTH-1:0]                         cpu_rspAddrOut,
    output logic [LINE_WIDTH-1:0]                         cpu_rspInsLineOut,
    output logic                                          mem_reqValidOut,
    output logic [ADDR_WIDTH-offset_width(LINE_WIDTH)-1:0] mem_reqTagOut,
    input  logic                                          mem_reqReadyIn,
    input  logic                                          mem_rspValidIn,
    input  logic [ADDR_WIDTH-offset_width(LINE_WIDTH)-1:0] mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0]                         mem_rspInsLineIn,
    input  logic                                          flushIn,
    output logic                                          hitStatusOut
);

    localparam int OFFSET_WIDTH = offset_width(LINE_WIDTH);
    localparam int INDEX_WIDTH  = index_width(NUM_SETS);
    localparam int TAG_WIDTH    = tag_width(ADDR_WIDTH, LINE_WIDTH, NUM_SETS);
    localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int WAY_WIDTH    = $clog2(NUM_WAYS);
    localparam int TREE_WIDTH   = NUM_WAYS - 1;

    t_ifu_cache_state state_r, state_next_s;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_r;
    logic [NUM_SETS-1:0][TREE_WIDTH-1:0] plru_r;
    logic [TAG_WIDTH-1:0]                tag_mem_r  [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0]               data_mem_r [NUM_SETS][NUM_WAYS];

    logic [ADDR_WIDTH-1:0] miss_addr_r, rsp_addr_r;
    logic [LINE_WIDTH-1:0] rsp_line_r;
    logic                  rsp_valid_r, hit_status_r, flush_pending_r;

    logic [INDEX_WIDTH-1:0] req_idx_s, miss_idx_s, sel_idx_s;
    logic [TAG_WIDTH-1:0]   req_tag_s, miss_tag_s;
    logic [LADDR_WIDTH-1:0] miss_laddr_s;
    logic [NUM_WAYS-1:0]    hit_vec_s;
    logic [WAY_WIDTH-1:0]   hit_way_s, fill_way_s, victim_s, access_way_s;
    logic [TREE_WIDTH-1:0]  tree_s, tree_next_s;
    logic                   hit_s, idle_s, ready_s, accept_s, fill_s, flush_now_s;

    assign req_idx_s    = cpu_reqAddrIn[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag_s    = cpu_reqAddrIn[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign miss_idx_s   = miss_addr_r[OFFSET_WIDTH +: INDEX_WIDTH];
    assign miss_tag_s   = miss_addr_r[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign miss_laddr_s = miss_addr_r[ADDR_WIDTH-1:OFFSET_WIDTH];

    assign idle_s      = (state_r == IDLE);
    assign ready_s     = idle_s && !flush_pending_r && !flushIn;
    assign accept_s    = ready_s && cpu_reqValidIn;
    assign fill_s      = (state_r == MISS_WAIT) && mem_rspValidIn && (mem_rspTagIn == miss_laddr_s);
    // Ready is low whenever this fires, so a flush never races an accept.
    assign flush_now_s = idle_s && (flush_pending_r || flushIn);
    assign hit_s       = |hit_vec_s;

    // Tag compare across all ways of the requested set; lowest matching way wins.
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[req_idx_s][w] && (tag_mem_r[req_idx_s][w] == req_tag_s);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec_s[w]) begin
                hit_way_s = WAY_WIDTH'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    // Fill way: lowest-index invalid way of the miss set, otherwise the PLRU victim.
    always_comb begin
        fill_way_s = victim_s;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_r[miss_idx_s][w]) begin
                fill_way_s = WAY_WIDTH'(w);
            end else begin
                fill_way_s = fill_way_s;
            end
        end
    end

    // The single PLRU helper looks at the request set in IDLE and the miss set otherwise.
    always_comb begin
        if (idle_s) begin
            sel_idx_s    = req_idx_s;
            access_way_s = hit_way_s;
        end else begin
            sel_idx_s    = miss_idx_s;
            access_way_s = fill_way_s;
        end
        tree_s = plru_r[sel_idx_s];
    end

    ifu_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .tree       (tree_s),
        .access_way (access_way_s),
        .victim     (victim_s),
        .next_tree  (tree_next_s)
    );

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !hit_s) begin
                    state_next_s = MISS_REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MISS_REQ: begin
                if (mem_reqReadyIn) begin
                    state_next_s = MISS_WAIT;
                end else begin
                    state_next_s = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                if (fill_s) begin
                    state_next_s = RESPOND;
                end else begin
                    state_next_s = MISS_WAIT;
                end
            end
            RESPOND:  state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Flush request remembered while a miss is in flight.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            flush_pending_r <= 1'b0;
        end else if (flush_now_s) begin
            flush_pending_r <= 1'b0;
        end else if (!idle_s && flushIn) begin
            flush_pending_r <= 1'b1;
        end
    end

    // Valid bits, PLRU trees, miss latch and the registered CPU response.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_r      <= '0;
            plru_r       <= '0;
            miss_addr_r  <= '0;
            rsp_addr_r   <= '0;
            rsp_line_r   <= '0;
            rsp_valid_r  <= 1'b0;
            hit_status_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            if (flush_now_s) begin
                valid_r <= '0;
                plru_r  <= '0;
            end else if (accept_s) begin
                hit_status_r <= hit_s;
                if (hit_s) begin
                    rsp_valid_r       <= 1'b1;
                    rsp_addr_r        <= cpu_reqAddrIn;
                    rsp_line_r        <= data_mem_r[req_idx_s][hit_way_s];
                    plru_r[req_idx_s] <= tree_next_s;
                end else begin
                    miss_addr_r <= cpu_reqAddrIn;
                end
            end else if (fill_s) begin
                valid_r[miss_idx_s][fill_way_s] <= 1'b1;
                plru_r[miss_idx_s]              <= tree_next_s;
                rsp_valid_r                     <= 1'b1;
                rsp_addr_r                      <= miss_addr_r;
                rsp_line_r                      <= mem_rspInsLineIn;
            end
        end
    end

    // Tag and data arrays: written on fill only, no reset (valid bits guard them).
    always_ff @(posedge Clock) begin
        if (fill_s) begin
            tag_mem_r[miss_idx_s][fill_way_s]  <= miss_tag_s;
            data_mem_r[miss_idx_s][fill_way_s] <= mem_rspInsLineIn;
        end
    end

    assign cpu_reqReadyOut   = ready_s;
    assign cpu_rspValidOut   = rsp_valid_r;
    assign cpu_rspAddrOut    = rsp_addr_r;
    assign cpu_rspInsLineOut = rsp_line_r;
    // Decoded from the state register so it falls as soon as Rst_n asserts.
    assign mem_reqValidOut   = (state_r == MISS_REQ);
    assign mem_reqTagOut     = miss_laddr_s;
    assign hitStatusOut      = hit_status_r;

endmodule

// File: tb/tb_ifu_sa_cache.sv
// tb_ifu_sa_cache: directed bench for ifu_sa_cache (4 ways, 4 sets, 16-byte lines).
module tb_ifu_sa_cache;
    import ifu_pkg::*;

    logic         Clock = 1'b0;
    logic         Rst_n;
    logic         cpu_reqValidIn;
    logic [31:0]  cpu_reqAddrIn;
    logic         cpu_reqReadyOut;
    logic         cpu_rspValidOut;
    logic [31:0]  cpu_rspAddrOut;
    logic [127:0] cpu_rspInsLineOut;
    logic         mem_reqValidOut;
    logic [27:0]  mem_reqTagOut;
    logic         mem_reqReadyIn;
    logic         mem_rspValidIn;
    logic [27:0]  mem_rspTagIn;
    logic [127:0] mem_rspInsLineIn;
    logic         flushIn;
    logic         hitStatusOut;

    int checks   = 0;
    int failures = 0;

    ifu_sa_cache dut (
        .Clock             (Clock),
        .Rst_n             (Rst_n),
        .cpu_reqValidIn    (cpu_reqValidIn),
        .cpu_reqAddrIn     (cpu_reqAddrIn),
        .cpu_reqReadyOut   (cpu_reqReadyOut),
        .cpu_rspValidOut   (cpu_rspValidOut),
        .cpu_rspAddrOut    (cpu_rspAddrOut),
        .cpu_rspInsLineOut (cpu_rspInsLineOut),
        .mem_reqValidOut   (mem_reqValidOut),
        .mem_reqTagOut     (mem_reqTagOut),
        .mem_reqReadyIn    (mem_reqReadyIn),
        .mem_rspValidIn    (mem_rspValidIn),
        .mem_rspTagIn      (mem_rspTagIn),
        .mem_rspInsLineIn  (mem_rspInsLineIn),
        .flushIn           (flushIn),
        .hitStatusOut      (hitStatusOut)
    );

    always #5 Clock = ~Clock;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {4{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Issue a request that must miss, then hand the line-fill request over after 'delay' cycles.
    task automatic miss_start(input logic [31:0] addr, input int delay);
        cpu_reqValidIn = 1'b1;
        cpu_reqAddrIn  = addr;
        tick;
        cpu_reqValidIn = 1'b0;
        chk("miss_mem_valid", 128'(mem_reqValidOut), 128'(1'b1));
        chk("miss_mem_tag", 128'(mem_reqTagOut), 128'(addr[31:4]));
        chk("miss_hit_status", 128'(hitStatusOut), 128'(1'b0));
        chk("miss_ready_low", 128'(cpu_reqReadyOut), 128'(1'b0));
        for (int i = 0; i < delay; i++) begin
            tick;
            chk("miss_mem_valid_held", 128'(mem_reqValidOut), 128'(1'b1));
        end
        mem_reqReadyIn = 1'b1;
        tick;
        mem_reqReadyIn = 1'b0;
        chk("wait_mem_valid_low", 128'(mem_reqValidOut), 128'(1'b0));
    endtask

    // Deliver fill data for addr; the response must appear for exactly one cycle.
    task automatic miss_fill(input logic [31:0] addr, input logic [127:0] line);
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = addr[31:4];
        mem_rspInsLineIn = line;
        tick;
        mem_rspValidIn = 1'b0;
        chk("fill_rsp_valid", 128'(cpu_rspValidOut), 128'(1'b1));
        chk("fill_rsp_line", cpu_rspInsLineOut, line);
        chk("fill_rsp_addr", 128'(cpu_rspAddrOut), 128'(addr));
        tick;
        chk("fill_rsp_drop", 128'(cpu_rspValidOut), 128'(1'b0));
    endtask

    task automatic hit_req(input logic [31:0] addr, input logic [127:0] line);
        cpu_reqValidIn = 1'b1;
        cpu_reqAddrIn  = addr;
        tick;
        cpu_reqValidIn = 1'b0;
        chk("hit_rsp_valid", 128'(cpu_rspValidOut), 128'(1'b1));
        chk("hit_rsp_line", cpu_rspInsLineOut, line);
        chk("hit_rsp_addr", 128'(cpu_rspAddrOut), 128'(addr));
        chk("hit_status", 128'(hitStatusOut), 128'(1'b1));
        chk("hit_no_mem_req", 128'(mem_reqValidOut), 128'(1'b0));
        tick;
        chk("hit_rsp_drop", 128'(cpu_rspValidOut), 128'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        Rst_n            = 1'b0;
        cpu_reqValidIn   = 1'b0;
        cpu_reqAddrIn    = 32'h0;
        mem_reqReadyIn   = 1'b0;
        mem_rspValidIn   = 1'b0;
        mem_rspTagIn     = 28'h0;
        mem_rspInsLineIn = 128'h0;
        flushIn          = 1'b0;

        // Reset
        repeat (2) @(posedge Clock);
        #1 Rst_n = 1'b1;
        #1;
        chk("rst_ready", 128'(cpu_reqReadyOut), 128'(1'b1));
        chk("rst_valids", 128'(dut.valid_r), 128'(16'h0000));
        chk("rst_tree0", 128'(dut.plru_r[0]), 128'(3'b000));
        chk("rst_mem_valid", 128'(mem_reqValidOut), 128'(1'b0));
        chk("rst_rsp_valid", 128'(cpu_rspValidOut), 128'(1'b0));
        chk("rst_hit_status", 128'(hitStatusOut), 128'(1'b0));

        // Cold miss on 0x1000, then hit
        miss_start(32'h0000_1000, 2);
        miss_fill(32'h0000_1000, {4{32'hDEAD_BEEF}});
        chk("cold_valid_set0", 128'(dut.valid_r[0]), 128'(4'b0001));
        chk("cold_tree0", 128'(dut.plru_r[0]), 128'(3'b011));
        chk("cold_ready", 128'(cpu_reqReadyOut), 128'(1'b1));
        hit_req(32'h0000_1000, {4{32'hDEAD_BEEF}});

        // Flush in IDLE empties the cache
        flushIn = 1'b1;
        #1;
        chk("flush_ready_low", 128'(cpu_reqReadyOut), 128'(1'b0));
        tick;
        flushIn = 1'b0;
        #1;
        chk("flush_valids", 128'(dut.valid_r), 128'(16'h0000));
        chk("flush_tree0", 128'(dut.plru_r[0]), 128'(3'b000));
        chk("flush_ready", 128'(cpu_reqReadyOut), 128'(1'b1));

        // Fill set 0 completely, then evict
        miss_start(32'h0000_0000, 0); miss_fill(32'h0000_0000, line_of(32'h0000_0000));
        miss_start(32'h0000_0040, 1); miss_fill(32'h0000_0040, line_of(32'h0000_0040));
        miss_start(32'h0000_0080, 0); miss_fill(32'h0000_0080, line_of(32'h0000_0080));
        miss_start(32'h0000_00C0, 0); miss_fill(32'h0000_00C0, line_of(32'h0000_00C0));
        chk("full_valid_set0", 128'(dut.valid_r[0]), 128'(4'b1111));
        chk("full_tree0", 128'(dut.plru_r[0]), 128'(3'b000));
        miss_start(32'h0000_0100, 0); miss_fill(32'h0000_0100, line_of(32'h0000_0100));
        chk("evict_tree0", 128'(dut.plru_r[0]), 128'(3'b011));
        hit_req(32'h0000_0040, line_of(32'h0000_0040));
        chk("hit1_tree0", 128'(dut.plru_r[0]), 128'(3'b001));
        // 0x000 was evicted; refill goes to way 2 per the tree
        miss_start(32'h0000_0000, 0); miss_fill(32'h0000_0000, line_of(32'h0000_0000));
        chk("refill_tree0", 128'(dut.plru_r[0]), 128'(3'b100));

        // Back-to-back hits at one per cycle
        cpu_reqValidIn = 1'b1;
        cpu_reqAddrIn  = 32'h0000_0040;
        tick;
        chk("b2b_rsp1_valid", 128'(cpu_rspValidOut), 128'(1'b1));
        chk("b2b_rsp1_line", cpu_rspInsLineOut, line_of(32'h0000_0040));
        chk("b2b_ready", 128'(cpu_reqReadyOut), 128'(1'b1));
        cpu_reqAddrIn = 32'h0000_00C4;
        tick;
        cpu_reqValidIn = 1'b0;
        chk("b2b_rsp2_valid", 128'(cpu_rspValidOut), 128'(1'b1));
        chk("b2b_rsp2_line", cpu_rspInsLineOut, line_of(32'h0000_00C0));
        chk("b2b_rsp2_addr", 128'(cpu_rspAddrOut), 128'(32'h0000_00C4));
        chk("b2b_tree0", 128'(dut.plru_r[0]), 128'(3'b000));
        tick;
        chk("b2b_rsp_drop", 128'(cpu_rspValidOut), 128'(1'b0));

        // Wrong-tag fill data is ignored
        miss_start(32'h0000_0200, 0);
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = 28'h7;
        mem_rspInsLineIn = line_of(32'h0000_0070);
        tick;
        mem_rspValidIn = 1'b0;
        chk("wrongtag_state", 128'(dut.state_r), 128'(MISS_WAIT));
        chk("wrongtag_rsp", 128'(cpu_rspValidOut), 128'(1'b0));
        chk("wrongtag_tree0", 128'(dut.plru_r[0]), 128'(3'b000));
        miss_fill(32'h0000_0200, line_of(32'h0000_0200));
        chk("righttag_tree0", 128'(dut.plru_r[0]), 128'(3'b011));

        // Flush raised during MISS_WAIT is deferred until the miss has responded
        miss_start(32'h0000_0300, 0);
        flushIn = 1'b1;
        tick;
        flushIn = 1'b0;
        chk("pend_flag", 128'(dut.flush_pending_r), 128'(1'b1));
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = 28'h30;
        mem_rspInsLineIn = line_of(32'h0000_0300);
        tick;
        mem_rspValidIn = 1'b0;
        chk("pend_rsp_valid", 128'(cpu_rspValidOut), 128'(1'b1));
        chk("pend_rsp_line", cpu_rspInsLineOut, line_of(32'h0000_0300));
        chk("pend_ready_resp", 128'(cpu_reqReadyOut), 128'(1'b0));
        tick;
        chk("pend_ready_idle", 128'(cpu_reqReadyOut), 128'(1'b0));
        chk("pend_valid_kept", 128'(dut.valid_r[0]), 128'(4'b1111));
        tick;
        chk("pend_valids_clr", 128'(dut.valid_r), 128'(16'h0000));
        chk("pend_ready_back", 128'(cpu_reqReadyOut), 128'(1'b1));
        miss_start(32'h0000_0040, 0);
        miss_fill(32'h0000_0040, line_of(32'h0000_0040));

        // Reset in MISS_REQ abandons the fill
        cpu_reqValidIn = 1'b1;
        cpu_reqAddrIn  = 32'h0000_0080;
        tick;
        cpu_reqValidIn = 1'b0;
        chk("mid_mem_valid", 128'(mem_reqValidOut), 128'(1'b1));
        Rst_n = 1'b0;
        #1;
        chk("mid_async_drop", 128'(mem_reqValidOut), 128'(1'b0));
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = 28'h8;
        mem_rspInsLineIn = line_of(32'h0000_0080);
        tick;
        Rst_n = 1'b1;
        tick;
        mem_rspValidIn = 1'b0;
        chk("mid_late_rsp", 128'(cpu_rspValidOut), 128'(1'b0));
        chk("mid_state", 128'(dut.state_r), 128'(IDLE));
        chk("mid_valids", 128'(dut.valid_r), 128'(16'h0000));
        chk("mid_ready", 128'(cpu_reqReadyOut), 128'(1'b1));

        // Only the accessed set's tree changes
        miss_start(32'h0000_1000, 0); miss_fill(32'h0000_1000, line_of(32'h0000_1000));
        miss_start(32'h0000_1010, 0); miss_fill(32'h0000_1010, line_of(32'h0000_1010));
        chk("set1_tree", 128'(dut.plru_r[1]), 128'(3'b011));
        chk("set0_tree", 128'(dut.plru_r[0]), 128'(3'b011));
        chk("set1_valid", 128'(dut.valid_r[1]), 128'(4'b0001));
        hit_req(32'h0000_101C, line_of(32'h0000_1010));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_sa_cache.md
Name: ifu_sa_cache

Overview:
- Parametrised N-way set-associative instruction cache for the IFU; successor to the single-set fully-associative ifu_cache.
- Sits between fetch (cpu_*) and the memory/line-fill path (mem_*).
- Per-set tree-PLRU replacement, valid/ready handshakes on both sides, one blocking outstanding miss, and a whole-cache flush.

Parameters:
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 128, bits per cache line (OFFSET_WIDTH = log2(LINE_WIDTH/8))
- NUM_WAYS, 4, associativity; power of 2, 2..16
- NUM_SETS, 4, number of sets; power of 2 (INDEX_WIDTH = log2(NUM_SETS), TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH)

Ports:
- Clock  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- cpu_reqValidIn  in  1  fetch request valid
- cpu_reqAddrIn  in  ADDR_WIDTH  fetch byte address
- cpu_reqReadyOut  out  1  cache can accept a request
- cpu_rspValidOut  out  1  response valid, one-cycle pulse
- cpu_rspAddrOut  out  ADDR_WIDTH  address of the responded request
- cpu_rspInsLineOut  out  LINE_WIDTH  instruction line
- mem_reqValidOut  out  1  line-fill request valid
- mem_reqTagOut  out  ADDR_WIDTH-OFFSET_WIDTH  line address requested
- mem_reqReadyIn  in  1  memory accepts request
- mem_rspValidIn  in  1  fill data valid
- mem_rspTagIn  in  ADDR_WIDTH-OFFSET_WIDTH  line address of fill data
- mem_rspInsLineIn  in  LINE_WIDTH  fill data
- flushIn  in  1  invalidate whole cache, level-sampled
- hitStatusOut  out  1  debug: last accepted request hit

Behaviour:
- Reset, asynchronous:
  - All valid bits 0; all PLRU trees 0; FSM IDLE; flush_pending 0.
  - Outputs: cpu_reqReadyOut 1 after reset release, all other outputs 0.
  - Data and tag arrays are not reset.
- Address split: {tag, index, offset}. Lookup compares the tag against all ways of the indexed set; hit = a valid way matches.
- FSM states: IDLE, MISS_REQ, MISS_WAIT, RESPOND.
  - IDLE:
    - cpu_reqReadyOut = !flush_pending && !flushIn.
    - A request is accepted on an edge with valid&&ready.
    - Hit: next cycle cpu_rspValidOut=1 with the registered line and address, PLRU updated, stay IDLE. Back-to-back hits at 1 request/cycle.
    - Miss: latch address, go to MISS_REQ.
  - MISS_REQ:
    - mem_reqValidOut=1, mem_reqTagOut = latched line address.
    - Held until the mem_reqReadyIn edge, then MISS_WAIT.
  - MISS_WAIT:
    - mem_rspValidIn with mem_rspTagIn == latched line address: write line and tag, set valid, update PLRU, go to RESPOND.
    - mem_rspValidIn with a non-matching tag: ignored, no state change.
  - RESPOND: cpu_rspValidOut=1 with the fill line for one cycle, then IDLE.
  - cpu_reqReadyOut=0 in every state except IDLE.
- Victim selection: lowest-index invalid way in the set; if none, the PLRU victim.
- Tree-PLRU per set:
  - NUM_WAYS-1 bits; node i has children 2i+1 and 2i+2.
  - Bit=0 means the victim lies in the left subtree.
  - On hit or fill of way w, each node on w's path is set to point away from w: 1 if w is left, 0 if w is right.
  - Only the accessed set's tree changes.
- Flush:
  - flushIn in IDLE, with no request accepted that cycle (ready is low): next edge clears all valids and all PLRU trees.
  - flushIn outside IDLE: sets flush_pending; executed in the first IDLE cycle; the in-flight miss still completes and responds first.
- Reset mid-miss: fill abandoned, mem_reqValidOut drops immediately, late mem_rspValidIn ignored.
- hitStatusOut: registered on each accepted request.

Decomposition:
- ifu_pkg adds:
  - parameter-derived widths OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH
  - t_ifu_cache_state enum {IDLE, MISS_REQ, MISS_WAIT, RESPOND}
  - tag-entry struct {valid, tag}
- Sub-module ifu_plru_tree (param NUM_WAYS): combinational victim index, plus next-tree given the current tree and the accessed way. Instantiated once and applied to the indexed set.

Test Plan (NUM_WAYS=4, NUM_SETS=4, 16B lines):
- Reset: hold Rst_n=0 for 2 cycles, release -> cpu_reqReadyOut=1, all valids 0, set 0 tree=3'b000, mem_reqValidOut=0.
- Cold miss: request 0x1000 -> mem_reqTagOut=0x100; mem_reqReadyIn after 2 cycles; respond tag 0x100 with DEADBEEF x4 -> cpu_rspValidOut one cycle with that line, way 0 valid, set 0 tree=3'b011; re-request 0x1000 -> hit, response next cycle, no mem request.
- Fill/eviction: fill 0x000, 0x040, 0x080, 0xC0 -> ways 0..3, set 0 tree=3'b000; request 0x100 -> way 0 (line 0x000) replaced; 0x040 still hits; 0x000 now misses.
- Wrong-tag response: during MISS_WAIT for 0x200, drive mem_rspValidIn with tag 0x7 -> ignored, state unchanged; a correct tag of 0x20 then completes the miss.
- Flush: flushIn during MISS_WAIT -> miss completes and responds, then the next cycle clears all valids; request 0x040 -> miss.
- Reset mid-miss: Rst_n low in MISS_REQ -> mem_reqValidOut drops asynchronously; after release the cache is empty and accepts a new request.
